// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX/MEM pipeline boundary.
// Optional performance counters in ex_mem_stage are enabled with EX_MEM_PERF_EN.
package ex_mem_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int M_READ   = 0;
  localparam int M_WRITE  = 1;
  localparam int M_BRANCH = 2;

  // Payload layout at the default widths; ex_mem_stage redeclares the same
  // field order with its own parameters so non-default builds stay consistent.
  typedef struct packed {
    logic [31:0] add;
    logic        zero;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [4:0]  dst;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] jumpAddr;
    logic        jump;
    logic        jr;
  } ex_mem_payload_t;

endpackage

// File: rtl/pipe_skid_buffer.sv
// Two-entry valid/ready skid buffer: a main register feeding the output and a
// skid register that absorbs one instruction when the consumer stalls.
module pipe_skid_buffer
  import ex_mem_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  state_t         state_q, state_d;
  logic [W-1:0]   mainData_q, mainData_d;
  logic [W-1:0]   skidData_q, skidData_d;
  logic           inReady_q;
  logic           accept;

  assign accept = in_valid_i & inReady_q;

  // Flush wins over every transition and leaves both data registers untouched.
  always_comb begin
    state_d    = state_q;
    mainData_d = mainData_q;
    skidData_d = skidData_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d    = HOLD;
            mainData_d = in_data_i;
          end
        end
        HOLD: begin
          if (accept && out_ready_i) begin
            mainData_d = in_data_i;
          end else if (accept) begin
            state_d    = FULL;
            skidData_d = in_data_i;
          end else if (out_ready_i) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_ready_i) begin
            state_d    = HOLD;
            mainData_d = skidData_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= EMPTY;
      mainData_q <= '0;
      skidData_q <= '0;
      inReady_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      mainData_q <= mainData_d;
      skidData_q <= skidData_d;
      inReady_q  <= (state_d != FULL);
    end
  end

  assign in_ready_o  = inReady_q;
  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = mainData_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary with valid/ready handshake, skid buffer and flush.
// Define EX_MEM_PERF_EN to add saturating stall_cnt / flush_cnt outputs.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int WB_W       = 2,
  parameter int M_W        = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     ex_add,
  input  logic                  ex_zero,
  input  logic [DATA_W-1:0]     ex_alu,
  input  logic [DATA_W-1:0]     ex_rd2,
  input  logic [REG_ADDR_W-1:0] ex_dst,
  input  logic [WB_W-1:0]       ex_wb,
  input  logic [M_W-1:0]        ex_m,
  input  logic [DATA_W-1:0]     ex_jump_addr,
  input  logic                  ex_jump,
  input  logic                  ex_jr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     mem_add,
  output logic [DATA_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wd,
  output logic [DATA_W-1:0]     mem_jump_addr,
  output logic                  mem_zero,
  output logic                  mem_jump,
  output logic                  mem_jr,
  output logic [REG_ADDR_W-1:0] mem_dst,
  output logic [WB_W-1:0]       mem_wb,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_branch
`ifdef EX_MEM_PERF_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0]     add;
    logic                  zero;
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     rd2;
    logic [REG_ADDR_W-1:0] dst;
    logic [WB_W-1:0]       wb;
    logic [M_W-1:0]        m;
    logic [DATA_W-1:0]     jumpAddr;
    logic                  jump;
    logic                  jr;
  } payload_t;

  payload_t inPayload;
  payload_t outPayload;
  logic     outValid;

  assign inPayload.add      = ex_add;
  assign inPayload.zero     = ex_zero;
  assign inPayload.alu      = ex_alu;
  assign inPayload.rd2      = ex_rd2;
  assign inPayload.dst      = ex_dst;
  assign inPayload.wb       = ex_wb;
  assign inPayload.m        = ex_m;
  assign inPayload.jumpAddr = ex_jump_addr;
  assign inPayload.jump     = ex_jump;
  assign inPayload.jr       = ex_jr;

  pipe_skid_buffer #(
    .W($bits(payload_t))
  ) u_skid (
    .clk_i      (clk),
    .rst_ni     (rst),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (inPayload),
    .out_valid_o(outValid),
    .out_ready_i(out_ready),
    .out_data_o (outPayload)
  );

  assign out_valid     = outValid;
  assign mem_add       = outPayload.add;
  assign mem_addr      = outPayload.alu;
  assign mem_wd        = outPayload.rd2;
  assign mem_jump_addr = outPayload.jumpAddr;
  assign mem_zero      = outPayload.zero;
  assign mem_dst       = outPayload.dst;

  // Control is qualified by valid so an empty slot (reset, flush, drain)
  // can never write memory or the register file, while data fields hold.
  assign mem_wb     = outValid ? outPayload.wb : '0;
  assign mem_read   = outValid & outPayload.m[M_READ];
  assign mem_write  = outValid & outPayload.m[M_WRITE];
  assign mem_branch = outValid & outPayload.m[M_BRANCH];
  assign mem_jump   = outValid & outPayload.jump;
  assign mem_jr     = outValid & outPayload.jr;

`ifdef EX_MEM_PERF_EN
  logic [CNT_W-1:0] stallCnt_q;
  logic [CNT_W-1:0] flushCnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      if (outValid && !out_ready && (stallCnt_q != '1))
        stallCnt_q <= stallCnt_q + CNT_W'(1);
      if (flush && outValid && (flushCnt_q != '1))
        flushCnt_q <= flushCnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stallCnt_q;
  assign flush_cnt = flushCnt_q;
`else
  localparam int unusedCntW = CNT_W;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage (perf counters checked when
// EX_MEM_PERF_EN is defined).
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ex_add, ex_alu, ex_rd2, ex_jump_addr;
  logic        ex_zero, ex_jump, ex_jr;
  logic [4:0]  ex_dst;
  logic [1:0]  ex_wb;
  logic [2:0]  ex_m;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] mem_add, mem_addr, mem_wd, mem_jump_addr;
  logic        mem_zero, mem_jump, mem_jr;
  logic [4:0]  mem_dst;
  logic [1:0]  mem_wb;
  logic        mem_read, mem_write, mem_branch;
`ifdef EX_MEM_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
  logic        in_ready2, out_valid2;
  logic [31:0] mem_add2, mem_addr2, mem_wd2, mem_jump_addr2;
  logic        mem_zero2, mem_jump2, mem_jr2;
  logic [4:0]  mem_dst2;
  logic [1:0]  mem_wb2;
  logic        mem_read2, mem_write2, mem_branch2;
  logic [1:0]  stall_cnt2, flush_cnt2;
`endif

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ex_add(ex_add), .ex_zero(ex_zero), .ex_alu(ex_alu), .ex_rd2(ex_rd2),
    .ex_dst(ex_dst), .ex_wb(ex_wb), .ex_m(ex_m), .ex_jump_addr(ex_jump_addr),
    .ex_jump(ex_jump), .ex_jr(ex_jr), .out_valid(out_valid), .out_ready(out_ready),
    .mem_add(mem_add), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_jump_addr(mem_jump_addr), .mem_zero(mem_zero), .mem_jump(mem_jump),
    .mem_jr(mem_jr), .mem_dst(mem_dst), .mem_wb(mem_wb), .mem_read(mem_read),
    .mem_write(mem_write), .mem_branch(mem_branch)
`ifdef EX_MEM_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

`ifdef EX_MEM_PERF_EN
  ex_mem_stage #(.CNT_W(2)) dutSat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .ex_add(ex_add), .ex_zero(ex_zero), .ex_alu(ex_alu), .ex_rd2(ex_rd2),
    .ex_dst(ex_dst), .ex_wb(ex_wb), .ex_m(ex_m), .ex_jump_addr(ex_jump_addr),
    .ex_jump(ex_jump), .ex_jr(ex_jr), .out_valid(out_valid2), .out_ready(out_ready),
    .mem_add(mem_add2), .mem_addr(mem_addr2), .mem_wd(mem_wd2),
    .mem_jump_addr(mem_jump_addr2), .mem_zero(mem_zero2), .mem_jump(mem_jump2),
    .mem_jr(mem_jr2), .mem_dst(mem_dst2), .mem_wb(mem_wb2), .mem_read(mem_read2),
    .mem_write(mem_write2), .mem_branch(mem_branch2),
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );
`endif

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Side fields are derived from alu so each instruction is recognisable.
  task automatic applyStimulus(input logic v, input logic [31:0] alu, input logic [2:0] m,
                               input logic rdy, input logic fl);
    in_valid     = v;
    ex_alu       = alu;
    ex_m         = m;
    out_ready    = rdy;
    flush        = fl;
    ex_add       = alu + 32'h100;
    ex_rd2       = ~alu;
    ex_dst       = alu[6:2];
    ex_wb        = 2'b10;
    ex_jump_addr = alu + 32'h200;
    ex_zero      = 1'b0;
    ex_jump      = 1'b0;
    ex_jr        = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b0;
    applyStimulus(1'b1, 32'h10, 3'b011, 1'b1, 1'b0);
    tick(); tick();
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("rst_mem_add", 64'(mem_add), 64'd0);
    checkOutput("rst_mem_wb", 64'(mem_wb), 64'd0);
    checkOutput("rst_mem_write", 64'(mem_write), 64'd0);

    rst = 1'b1;
    #1;
    checkOutput("rel_before_edge_valid", 64'(out_valid), 64'd0);
    applyStimulus(1'b1, 32'h10, 3'b000, 1'b1, 1'b0);
    tick();
    checkOutput("first_valid", 64'(out_valid), 64'd1);
    checkOutput("stream0_addr", 64'(mem_addr), 64'h10);
    applyStimulus(1'b1, 32'h14, 3'b000, 1'b1, 1'b0);
    tick();
    checkOutput("stream1_addr", 64'(mem_addr), 64'h14);
    checkOutput("stream1_wd", 64'(mem_wd), 64'hFFFF_FFEB);
    checkOutput("stream1_ready", 64'(in_ready), 64'd1);
    applyStimulus(1'b1, 32'h18, 3'b000, 1'b1, 1'b0);
    tick();
    checkOutput("stream2_addr", 64'(mem_addr), 64'h18);
    checkOutput("stream2_valid", 64'(out_valid), 64'd1);
    checkOutput("stream2_jaddr", 64'(mem_jump_addr), 64'h218);
    applyStimulus(1'b0, 32'h1C, 3'b000, 1'b1, 1'b0);
    tick();
    checkOutput("drain_valid", 64'(out_valid), 64'd0);
    checkOutput("drain_wb", 64'(mem_wb), 64'd0);
    checkOutput("drain_addr_hold", 64'(mem_addr), 64'h18);

    applyStimulus(1'b1, 32'hA0, 3'b000, 1'b0, 1'b0);
    tick();
    checkOutput("bp_a0_addr", 64'(mem_addr), 64'hA0);
    checkOutput("bp_a0_ready", 64'(in_ready), 64'd1);
    applyStimulus(1'b1, 32'hA4, 3'b000, 1'b0, 1'b0);
    tick();
    checkOutput("bp_full_ready", 64'(in_ready), 64'd0);
    checkOutput("bp_full_addr", 64'(mem_addr), 64'hA0);
    applyStimulus(1'b1, 32'hA8, 3'b000, 1'b0, 1'b0);
    tick();
    checkOutput("bp_hold_addr", 64'(mem_addr), 64'hA0);
    checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
    applyStimulus(1'b1, 32'hAC, 3'b000, 1'b1, 1'b0);
    tick();
    checkOutput("bp_skid_addr", 64'(mem_addr), 64'hA4);
    checkOutput("bp_skid_ready", 64'(in_ready), 64'd1);
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    tick();
    checkOutput("bp_empty_valid", 64'(out_valid), 64'd0);

    applyStimulus(1'b1, 32'hB0, 3'b010, 1'b0, 1'b0);
    tick();
    checkOutput("fl_store_write", 64'(mem_write), 64'd1);
    applyStimulus(1'b1, 32'hB4, 3'b010, 1'b0, 1'b0);
    tick();
    checkOutput("fl_full_ready", 64'(in_ready), 64'd0);
    applyStimulus(1'b1, 32'hB8, 3'b010, 1'b0, 1'b1);
    tick();
    checkOutput("fl_valid", 64'(out_valid), 64'd0);
    checkOutput("fl_write", 64'(mem_write), 64'd0);
    checkOutput("fl_ready", 64'(in_ready), 64'd1);
    checkOutput("fl_addr_hold", 64'(mem_addr), 64'hB0);
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    tick();
    checkOutput("fl_after_valid", 64'(out_valid), 64'd0);

    applyStimulus(1'b1, 32'hC0, 3'b001, 1'b1, 1'b0);
    tick();
    checkOutput("flh_read", 64'(mem_read), 64'd1);
    applyStimulus(1'b1, 32'hC4, 3'b010, 1'b1, 1'b1);
    tick();
    checkOutput("flh_valid", 64'(out_valid), 64'd0);
    checkOutput("flh_addr_hold", 64'(mem_addr), 64'hC0);
    checkOutput("flh_read_clr", 64'(mem_read), 64'd0);

    applyStimulus(1'b1, 32'h20, 3'b101, 1'b1, 1'b0);
    ex_wb = 2'b11; ex_jump = 1'b1; ex_jr = 1'b1; ex_jump_addr = 32'h400;
    ex_add = 32'h1000; ex_rd2 = 32'hDEAD_BEEF; ex_dst = 5'd7; ex_zero = 1'b1;
    tick();
    checkOutput("dec_read", 64'(mem_read), 64'd1);
    checkOutput("dec_write", 64'(mem_write), 64'd0);
    checkOutput("dec_branch", 64'(mem_branch), 64'd1);
    checkOutput("dec_wb", 64'(mem_wb), 64'd3);
    checkOutput("dec_jump", 64'(mem_jump), 64'd1);
    checkOutput("dec_jr", 64'(mem_jr), 64'd1);
    checkOutput("dec_jaddr", 64'(mem_jump_addr), 64'h400);
    checkOutput("dec_add", 64'(mem_add), 64'h1000);
    checkOutput("dec_wd", 64'(mem_wd), 64'hDEAD_BEEF);
    checkOutput("dec_dst", 64'(mem_dst), 64'd7);
    checkOutput("dec_zero", 64'(mem_zero), 64'd1);

    applyStimulus(1'b1, 32'hE0, 3'b010, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'hE4, 3'b010, 1'b0, 1'b0);
    tick();
    #2;
    rst = 1'b0;
    #1;
    checkOutput("mrst_valid", 64'(out_valid), 64'd0);
    checkOutput("mrst_addr", 64'(mem_addr), 64'd0);
    checkOutput("mrst_ready", 64'(in_ready), 64'd1);
    #1;
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    tick();
    checkOutput("mrst_no_leftover", 64'(out_valid), 64'd0);

`ifdef EX_MEM_PERF_EN
    applyStimulus(1'b1, 32'hD0, 3'b000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("perf_stall5", 64'(stall_cnt), 64'd5);
    checkOutput("perf_sat_stall", 64'(stall_cnt2), 64'd3);
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 32'hD4, 3'b000, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b1, 1'b1);
    tick();
    checkOutput("perf_flush2", 64'(flush_cnt), 64'd2);
    tick();
    checkOutput("perf_flush_empty", 64'(flush_cnt), 64'd2);
    checkOutput("perf_stall_final", 64'(stall_cnt), 64'd5);
    applyStimulus(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
